// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port data DRAM between two requesters.
// Port 0 is the load/store unit and has fixed priority. Port 1 is the
// DMA/debug loader; a starvation counter forces a port 1 grant after
// STARVE_LIMIT back-to-back port 0 grants while port 1 is waiting.
// The DRAM read latency is one cycle; the arbiter records who owns the
// access in flight and steers the returning word to that port.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   m0_req/addr/we/wdata          port 0 request (we = 0 -> read)
//   m0_gnt                        port 0 granted this cycle (comb.)
//   m0_rvalid/rdata               port 0 response, one cycle after grant
//   m1_*                          same set for port 1
//   dram_a/we/din                 DRAM address, byte enables, write data
//   dram_spo                      DRAM read data, one cycle after dram_a
//   perf_m0_grants                port 0 grant count
//   perf_m1_grants                port 1 grant count
//   perf_conflicts                cycles with both requests raised
//
// Build option: define DRAM_ARB_PERF_EN to get the three performance
// counters; without it the perf ports read as zero and no counter
// flops exist. Arbitration and response timing do not depend on it.
module dram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [3:0]            m0_we,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [3:0]            m1_we,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic [ADDR_WIDTH-1:0] dram_a,
  output logic [3:0]            dram_we,
  output logic [31:0]           dram_din,
  input  logic [31:0]           dram_spo,

  output logic [31:0]           perf_m0_grants,
  output logic [31:0]           perf_m1_grants,
  output logic [31:0]           perf_conflicts
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Owner encoding of the access in flight.
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  logic [7:0] starve_q;
  logic [7:0] starve_d;
  logic       rvalid_q;
  logic       rvalid_d;
  logic       owner_q;
  logic       owner_d;

  logic       gnt0;
  logic       gnt1;
  logic       m1_forced;

  // -------------------------------------------------------------
  // Arbitration. Nothing is granted while reset is held so that
  // the DRAM never sees a write enable during reset.
  // -------------------------------------------------------------
  assign m1_forced = (starve_q == LIMIT);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m1_req && (!m0_req || m1_forced)) begin
        gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // -------------------------------------------------------------
  // DRAM drive. Idle cycles park the address on port 0 and keep
  // write enables and write data at zero.
  // -------------------------------------------------------------
  always_comb begin
    dram_a   = m0_addr;
    dram_we  = 4'b0000;
    dram_din = 32'h0;
    if (gnt1) begin
      dram_a   = m1_addr;
      dram_we  = m1_we;
      dram_din = m1_wdata;
    end else if (gnt0) begin
      dram_a   = m0_addr;
      dram_we  = m0_we;
      dram_din = m0_wdata;
    end
  end

  // -------------------------------------------------------------
  // Starvation counter: counts port 0 wins while port 1 waits.
  // Any cycle where port 1 is not waiting, or port 1 wins,
  // starts the count over.
  // -------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (gnt1 || !m1_req) begin
      starve_d = 8'd0;
    end else if (gnt0 && (starve_q != LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // -------------------------------------------------------------
  // Response tracking. Reads and writes both return one word,
  // so every grant produces exactly one rvalid next cycle.
  // -------------------------------------------------------------
  always_comb begin
    rvalid_d = gnt0 | gnt1;
    owner_d  = owner_q;
    if (gnt1) begin
      owner_d = OWN_M1;
    end else if (gnt0) begin
      owner_d = OWN_M0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 8'd0;
      rvalid_q <= 1'b0;
      owner_q  <= OWN_M0;
    end else begin
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  assign m0_rvalid = rvalid_q & (owner_q == OWN_M0);
  assign m1_rvalid = rvalid_q & (owner_q == OWN_M1);

  // Only the owning port sees the DRAM word; the other reads zero.
  assign m0_rdata = m0_rvalid ? dram_spo : 32'h0;
  assign m1_rdata = m1_rvalid ? dram_spo : 32'h0;

  // -------------------------------------------------------------
  // Performance counters (optional).
  // -------------------------------------------------------------
`ifdef DRAM_ARB_PERF_EN
  logic [31:0] pm0_q;
  logic [31:0] pm0_d;
  logic [31:0] pm1_q;
  logic [31:0] pm1_d;
  logic [31:0] pcf_q;
  logic [31:0] pcf_d;

  always_comb begin
    pm0_d = pm0_q;
    pm1_d = pm1_q;
    pcf_d = pcf_q;
    if (gnt0) begin
      pm0_d = pm0_q + 32'd1;
    end
    if (gnt1) begin
      pm1_d = pm1_q + 32'd1;
    end
    if (m0_req && m1_req) begin
      pcf_d = pcf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm0_q <= 32'h0;
      pm1_q <= 32'h0;
      pcf_q <= 32'h0;
    end else begin
      pm0_q <= pm0_d;
      pm1_q <= pm1_d;
      pcf_q <= pcf_d;
    end
  end

  assign perf_m0_grants = pm0_q;
  assign perf_m1_grants = pm1_q;
  assign perf_conflicts = pcf_q;
`else
  assign perf_m0_grants = 32'h0;
  assign perf_m1_grants = 32'h0;
  assign perf_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter with a DRAM model.
// Expected responses come from a shadow memory and an arbitration model.
module tb_dram_arbiter;

  localparam int AW    = 16;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_we, m1_we;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] dram_a;
  logic [3:0]    dram_we;
  logic [31:0]   dram_din;
  logic [31:0]   dram_spo;
  logic [31:0]   perf_m0_grants, perf_m1_grants, perf_conflicts;

  dram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .dram_a(dram_a), .dram_we(dram_we), .dram_din(dram_din),
    .dram_spo(dram_spo),
    .perf_m0_grants(perf_m0_grants),
    .perf_m1_grants(perf_m1_grants),
    .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DRAM model: synchronous read of the old word, byte-lane write.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    dram_spo <= mem[dram_a[7:0]];
    for (int b = 0; b < 4; b++)
      if (dram_we[b]) mem[dram_a[7:0]][8*b +: 8] <= dram_din[8*b +: 8];
  end

  // Reference state
  logic [31:0] ref_mem [0:255];
  int m0_run;  // m0 wins in a row while m1 has been waiting

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, check grant and DRAM bus at negedge,
  // push the expected response and update the reference model.
  task automatic step(input bit r0, input logic [AW-1:0] a0,
                      input logic [3:0] w0, input logic [31:0] d0,
                      input bit r1, input logic [AW-1:0] a1,
                      input logic [3:0] w1, input logic [31:0] d1,
                      output int g);
    int          ew;
    logic [AW-1:0] ea;
    logic [3:0]  ewe;
    logic [31:0] ed;
    exp_t        e;
    m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    @(negedge clk);
    if (r1 && (!r0 || m0_run >= LIMIT)) ew = 2;
    else if (r0) ew = 1;
    else ew = 0;
    g = int'({m1_gnt, m0_gnt});
    chk("gnt", {m1_gnt, m0_gnt}, 64'(ew));
    ea = a0; ewe = 4'b0; ed = 32'h0;
    if (ew == 2) begin ea = a1; ewe = w1; ed = d1; end
    if (ew == 1) begin ea = a0; ewe = w0; ed = d0; end
    chk("dram_a", dram_a, ea);
    chk("dram_we", dram_we, ewe);
    chk("dram_din", dram_din, ed);
    if (ew != 0) begin
      e.port = (ew == 2);
      e.data = ref_mem[ea[7:0]];
      e.due  = cyc + 1;
      sbq.push_back(e);
      for (int b = 0; b < 4; b++)
        if (ewe[b]) ref_mem[ea[7:0]][8*b +: 8] = ed[8*b +: 8];
    end
    if (ew == 2 || !r1) m0_run = 0;
    else if (ew == 1 && m0_run < LIMIT) m0_run++;
  endtask

  task automatic idle_step(output int g);
    step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 4'h0, 32'h0, g);
  endtask

  // Monitor: every negedge, pop the response due now or demand silence.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("rvalid", {m1_rvalid, m0_rvalid}, e.port ? 2'b10 : 2'b01);
        chk("rdata", e.port ? m1_rdata : m0_rdata, e.data);
      end else begin
        chk("no_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      end
      if (!m0_rvalid) chk("m0_rdata_gate", m0_rdata, 0);
      if (!m1_rvalid) chk("m1_rdata_gate", m1_rdata, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int bad;
    bit p0, p1;
    logic [AW-1:0] ra0, ra1;
    logic [3:0] rw0, rw1;
    logic [31:0] rd0, rd1;
    logic [31:0] s0, s1, sc;
    logic [31:0] v;

    rst = 1'b1;
    m0_req = 1; m0_addr = 16'h5; m0_we = 4'hF; m0_wdata = 32'h1;
    m1_req = 1; m1_addr = 16'h6; m1_we = 4'hF; m1_wdata = 32'h2;
    m0_run = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 16) v = 32'hDEADBEEF;
      if (i == 32) v = 32'h11223344;
      ref_mem[i] = v;
      mem[i] <= v;
    end
    fork monitor(); join_none

    // Reset: no grants, no writes, no responses despite requests
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("rst_dram_we", dram_we, 4'b0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    end
    adv();
    rst = 1'b0;

    // Single read
    step(1, 16'h0010, 4'h0, 32'h0, 0, 16'h0, 4'h0, 32'h0, g);
    adv();
    idle_step(g);
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    adv();

    // Byte write from m1, then read back from m0
    step(0, 16'h0, 4'h0, 32'h0, 1, 16'h0020, 4'b0010, 32'h0000AB00, g);
    adv();
    step(1, 16'h0020, 4'h0, 32'h0, 0, 16'h0, 4'h0, 32'h0, g);
    chk("t2_m1_rdata", m1_rdata, 32'h11223344);
    adv();
    idle_step(g);
    chk("t2_m0_rdata", m0_rdata, 32'h1122AB44);
    adv();

    // Contention for 20 cycles: 8x m0, 1x m1, repeating
    s0 = perf_m0_grants; s1 = perf_m1_grants; sc = perf_conflicts;
    for (int i = 0; i < 20; i++) begin
      step(1, 16'h5, 4'h0, 32'h0, 1, 16'h6, 4'h0, 32'h0, g);
      chk("t3_pattern", 64'(g), (i % 9 == 8) ? 64'd2 : 64'd1);
      adv();
    end
`ifdef DRAM_ARB_PERF_EN
    chk("perf_conflicts", perf_conflicts - sc, 20);
    chk("perf_m0_grants", perf_m0_grants - s0, 18);
    chk("perf_m1_grants", perf_m1_grants - s1, 2);
`else
    chk("perf_conflicts", perf_conflicts, 0);
    chk("perf_m0_grants", perf_m0_grants, 0);
    chk("perf_m1_grants", perf_m1_grants, 0);
`endif
    idle_step(g);
    adv();

    // Back-to-back reads (monitor checks the exact cycle of each)
    for (int i = 1; i <= 3; i++) begin
      step(1, 16'(i), 4'h0, 32'h0, 0, 16'h0, 4'h0, 32'h0, g);
      adv();
    end
    idle_step(g);
    adv();

    // Reset in the cycle after an m1 read grant
    step(0, 16'h0, 4'h0, 32'h0, 1, 16'h0007, 4'h0, 32'h0, g);
    @(posedge clk);
    rst = 1'b1;
    sbq.delete();
    m0_run = 0;
    m0_req = 0; m1_req = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    end
    adv();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1, 16'h8, 4'h0, 32'h0, 1, 16'h9, 4'h0, 32'h0, g);
      chk("t5_pattern", 64'(g), (i == 8) ? 64'd2 : 64'd1);
      adv();
    end
    idle_step(g);
    adv();

    // Randomized traffic with hold-until-granted requesters
    p0 = 0; p1 = 0;
    ra0 = 0; ra1 = 0; rw0 = 0; rw1 = 0; rd0 = 0; rd1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1;
        ra0 = 16'($urandom_range(0, 31));
        rw0 = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        rd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) != 0) begin
        p1 = 1;
        ra1 = 16'($urandom_range(0, 31));
        rw1 = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        rd1 = $urandom;
      end
      step(p0, ra0, rw0, rd0, p1, ra1, rw1, rd1, g);
      if (g == 1) p0 = 0;
      else if (g == 2) p1 = 0;
      adv();
    end

    // Idle: no writes, no responses, memory untouched
    for (int i = 0; i < 10; i++) begin
      idle_step(g);
      adv();
    end
    repeat (2) adv();
    chk("queue_drain", 64'(sbq.size()), 0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", 64'(bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
